// File: rtl/lut3d_pkg.sv
// Shared types and address arithmetic for the 3x3x3 lookup-table access scheduler.
package lut3d_pkg;

    localparam int LUT_DIM   = 3;
    localparam int LUT_DEPTH = LUT_DIM * LUT_DIM * LUT_DIM;
    localparam int ADDR_W    = 5;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] c;
    } lut_idx_t;

    typedef struct packed {
        logic              oor;
        logic [ADDR_W-1:0] addr;
    } lut_addr_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    // A field value of 3 lies outside the table; the address is forced to 0 then.
    function automatic lut_addr_t lut_addr(lut_idx_t idx);
        lut_addr_t r;
        r.oor  = (idx.a == 2'd3) || (idx.b == 2'd3) || (idx.c == 2'd3);
        r.addr = r.oor ? '0
                       : ADDR_W'(idx.a) * ADDR_W'(LUT_DIM * LUT_DIM)
                       + ADDR_W'(idx.b) * ADDR_W'(LUT_DIM)
                       + ADDR_W'(idx.c);
        return r;
    endfunction

endpackage

// File: rtl/lut3d_access_sched_if.sv
// Requester, configuration and status signals of the lookup-table access scheduler.
interface lut3d_access_sched_if #(
    parameter int NREQ = 4,
    parameter int DW   = 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*6-1:0] req_idx;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic              cfg_we;
    logic [5:0]        cfg_idx;
    logic [DW-1:0]     cfg_data;
    logic              cfg_ready;
    logic              cfg_err;
    logic              busy;

    modport master (
        output req_valid, req_idx, cfg_we, cfg_idx, cfg_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, cfg_ready, cfg_err, busy
    );

    modport slave (
        input  req_valid, req_idx, cfg_we, cfg_idx, cfg_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, cfg_ready, cfg_err, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after a rotating pointer.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    int            j;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        j       = 0;
        if (en_i) begin
            // Scan downwards so the requester closest to the pointer wins last.
            for (int k = NREQ - 1; k >= 0; k--) begin
                j = (int'(ptr_q) + k) % NREQ;
                if (req_i[j]) begin
                    grant_o    = '0;
                    grant_o[j] = 1'b1;
                    ptr_d      = PW'((j + 1) % NREQ);
                end
            end
        end
    end

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/lut3d_access_sched.sv
// Owns the 27-entry table, clears it after reset and serialises writes and
// round-robin lookups onto one access per cycle with a registered response.
module lut3d_access_sched
    import lut3d_pkg::*;
#(
    parameter int            NREQ     = 4,
    parameter int            DW       = 1,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lut3d_access_sched_if.slave  bus
);
    sched_state_t      state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              cfg_err_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [DW-1:0]     rsp_data_q;
    logic              rsp_err_q;
    logic [DW-1:0]     table_q [LUT_DEPTH];

    logic              run;
    logic              cfg_take;
    logic [NREQ-1:0]   grant;
    logic              grant_any;
    lut_idx_t          rd_idx;
    lut_addr_t         rd_a;
    lut_addr_t         cfg_a;
    logic              tbl_we;
    logic [ADDR_W-1:0] tbl_waddr;
    logic [DW-1:0]     tbl_wdata;

    assign run       = (state_q == RUN);
    assign cfg_take  = run && bus.cfg_we;
    assign grant_any = |grant;
    assign cfg_a     = lut_addr(lut_idx_t'(bus.cfg_idx));
    assign rd_a      = lut_addr(rd_idx);

    // Configuration writes pre-empt lookups, so the arbiter only runs when no write is pending.
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (bus.req_valid),
        .en_i    (run && !bus.cfg_we),
        .grant_o (grant)
    );

    always_comb begin
        rd_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) rd_idx = lut_idx_t'(bus.req_idx[6*i +: 6]);
        end
    end

    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = cfg_a.addr;
        tbl_wdata = bus.cfg_data;
        if (!run) begin
            tbl_we    = 1'b1;
            tbl_waddr = cnt_q;
            tbl_wdata = INIT_VAL;
        end else if (cfg_take && !cfg_a.oor) begin
            tbl_we = 1'b1;
        end
    end

    // NOTE: the table has no reset; the INIT sweep clears it, which keeps it mappable onto RAM.
    always_ff @(posedge clk) begin
        if (tbl_we) table_q[tbl_waddr] <= tbl_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            cfg_err_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= grant;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            if (grant_any) begin
                if (rd_a.oor) rsp_err_q  <= 1'b1;
                else          rsp_data_q <= table_q[rd_a.addr];
            end
            case (state_q)
                INIT: begin
                    if (cnt_q == ADDR_W'(LUT_DEPTH - 1)) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
                RUN: begin
                    if (cfg_take && cfg_a.oor) cfg_err_q <= 1'b1;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign bus.cfg_ready = cfg_take;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.busy      = !run;

endmodule

// File: tb/tb_lut3d_access_sched.sv
// Scoreboard bench for lut3d_access_sched: a spec-level reference model predicts
// grants and responses, and a separate monitor compares the registered responses.
module tb_lut3d_access_sched;

    localparam int            NREQ     = 4;
    localparam int            DW       = 1;
    localparam logic [DW-1:0] INIT_VAL = '0;
    localparam int            DEPTH    = 27;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lut3d_access_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();

    lut3d_access_sched #(.NREQ(NREQ), .DW(DW), .INIT_VAL(INIT_VAL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [DW-1:0]   data;
        logic            err;
        int              due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [DW-1:0] ref_tbl [DEPTH];
    int          ref_ptr;
    int          ref_init_edges;
    logic        ref_cfg_err;
    int          last_grant;
    bit          last_cfg_acc;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, wanted %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit idx_oor(logic [5:0] x);
        return (x[5:4] == 2'd3) || (x[3:2] == 2'd3) || (x[1:0] == 2'd3);
    endfunction

    function automatic int idx_addr(logic [5:0] x);
        return int'(x[5:4]) * 9 + int'(x[3:2]) * 3 + int'(x[1:0]);
    endfunction

    function automatic logic [5:0] rand_idx();
        if ($urandom_range(7) == 0) return 6'($urandom);
        return {2'($urandom_range(2)), 2'($urandom_range(2)), 2'($urandom_range(2))};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_tbl[i] = INIT_VAL;
        ref_ptr        = 0;
        ref_init_edges = 0;
        ref_cfg_err    = 1'b0;
        sb.delete();
    endtask

    task automatic set_req(input int i, input logic v, input logic [5:0] idx);
        bus.req_valid[i]       = v;
        bus.req_idx[6*i +: 6]  = idx;
    endtask

    // Predicts this cycle's access from the present inputs and queues the response.
    task automatic model_eval();
        logic [NREQ-1:0] exp_rdy;
        logic            exp_cfg_rdy;
        logic [5:0]      x;
        exp_t            e;
        bit              busy_m;
        int              j;
        busy_m       = (ref_init_edges < DEPTH);
        exp_rdy      = '0;
        exp_cfg_rdy  = 1'b0;
        last_grant   = -1;
        last_cfg_acc = 1'b0;
        check("busy", bus.busy, busy_m);
        check("cfg_err", bus.cfg_err, ref_cfg_err);
        if (!busy_m) begin
            if (bus.cfg_we) begin
                exp_cfg_rdy  = 1'b1;
                last_cfg_acc = 1'b1;
                if (idx_oor(bus.cfg_idx)) ref_cfg_err = 1'b1;
                else ref_tbl[idx_addr(bus.cfg_idx)] = bus.cfg_data;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    j = (ref_ptr + k) % NREQ;
                    if (bus.req_valid[j]) begin
                        last_grant = j;
                        break;
                    end
                end
                if (last_grant >= 0) begin
                    exp_rdy[last_grant] = 1'b1;
                    ref_ptr = (last_grant + 1) % NREQ;
                    x       = bus.req_idx[6*last_grant +: 6];
                    e.valid = exp_rdy;
                    e.err   = idx_oor(x);
                    e.data  = e.err ? '0 : ref_tbl[idx_addr(x)];
                    e.due   = cyc + 1;
                    sb.push_back(e);
                end
            end
        end
        check("req_ready", bus.req_ready, exp_rdy);
        check("cfg_ready", bus.cfg_ready, exp_cfg_rdy);
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
        if (ref_init_edges < DEPTH) ref_init_edges++;
    endtask

    task automatic read_all();
        bus.cfg_we = 1'b0;
        bus.req_valid = '0;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                for (int c = 0; c < 3; c++) begin
                    set_req(0, 1'b1, {2'(a), 2'(b), 2'(c)});
                    tick();
                end
        set_req(0, 1'b0, 6'd0);
    endtask

    // Response monitor: pops the entry due this cycle, otherwise expects an idle response.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_e.valid = '0;
            mon_e.data  = '0;
            mon_e.err   = 1'b0;
            mon_e.due   = 0;
            if (sb.size() > 0 && sb[0].due <= cyc) mon_e = sb.pop_front();
            check("rsp_valid", bus.rsp_valid, mon_e.valid);
            check("rsp_data", bus.rsp_data, mon_e.data);
            check("rsp_err", bus.rsp_err, mon_e.err);
        end
    end

    initial begin
        bus.req_valid = '0;
        bus.req_idx   = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_idx   = '0;
        bus.cfg_data  = '0;
        model_reset();

        // Init sweep with every requester asserting; then eight round-robin grants.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, rand_idx());
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (DEPTH) tick();
        repeat (8) begin
            tick();
            if (last_grant >= 0) set_req(last_grant, 1'b1, rand_idx());
        end
        bus.req_valid = '0;
        tick();

        // Read-after-write on address 15.
        bus.cfg_we = 1'b1; bus.cfg_idx = 6'b01_10_00; bus.cfg_data = 1'b1;
        tick();
        bus.cfg_we = 1'b0;
        set_req(0, 1'b1, 6'b01_10_00);
        tick();
        set_req(0, 1'b0, 6'd0);
        tick();

        // Write and lookup in the same cycle: write wins, lookup follows.
        bus.cfg_we = 1'b1; bus.cfg_idx = 6'b10_00_01; bus.cfg_data = 1'b1;
        set_req(2, 1'b1, 6'b10_00_01);
        tick();
        bus.cfg_we = 1'b0;
        tick();
        set_req(2, 1'b0, 6'd0);
        tick();

        // Out-of-range lookup and write, then the whole table read back.
        set_req(1, 1'b1, 6'b00_11_01);
        tick();
        set_req(1, 1'b0, 6'd0);
        bus.cfg_we = 1'b1; bus.cfg_idx = 6'b01_01_11; bus.cfg_data = 1'b1;
        tick();
        read_all();

        // Randomised mix of writes and lookups.
        repeat (400) begin
            tick();
            if (last_grant >= 0) set_req(last_grant, ($urandom_range(9) < 7), rand_idx());
            for (int i = 0; i < NREQ; i++)
                if (!bus.req_valid[i] && $urandom_range(3) == 0) set_req(i, 1'b1, rand_idx());
            if (last_cfg_acc || !bus.cfg_we) begin
                bus.cfg_we   = ($urandom_range(3) == 0);
                bus.cfg_idx  = rand_idx();
                bus.cfg_data = DW'($urandom);
            end
        end

        // Reset pulse while a response is on the outputs.
        bus.cfg_we = 1'b0;
        bus.req_valid = '0;
        set_req(3, 1'b1, 6'b00_00_10);
        tick();
        bus.cfg_we = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", bus.rsp_valid, '0);
        check("rst_rsp_data", bus.rsp_data, '0);
        check("rst_rsp_err", bus.rsp_err, 1'b0);
        check("rst_busy", bus.busy, 1'b1);
        check("rst_req_ready", bus.req_ready, '0);
        check("rst_cfg_ready", bus.cfg_ready, 1'b0);
        check("rst_cfg_err", bus.cfg_err, 1'b0);
        model_reset();
        bus.cfg_we = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, rand_idx());
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (DEPTH) tick();
        read_all();

        bus.req_valid = '0;
        repeat (3) tick();
        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
